// File: rtl/hidden_cpu_prog_feeder.sv
// Program streamer for the HiddenCPU pin interface: buffers a program, holds the CPU in reset, then issues it.
// Optional single-step issue is compiled in when HIDDENCPU_FEEDER_STEP_EN is defined.
module hidden_cpu_prog_feeder #(
   parameter int         DEPTH      = 16,
   parameter int         AW         = 4,
   parameter int         RST_CYCLES = 2,
   parameter logic [5:0] IDLE_INSTR = 6'b000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [5:0]    load_data,
   input  logic          clear,
   input  logic          start,
   input  logic [7:0]    repeat_cnt,
   input  logic          abort,
`ifdef HIDDENCPU_FEEDER_STEP_EN
   input  logic          step,
   input  logic          step_mode,
`endif
   output logic          busy,
   output logic          done,
   output logic [AW:0]   prog_len,
   output logic          cpu_rst,
   output logic [5:0]    cpu_instr
);

   localparam int CW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RESET_CPU = 2'd1,
      S_RUN       = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     prog_len_q, prog_len_d;
   logic [7:0]      loops_left_q, loops_left_d;
   logic [CW-1:0]   rst_cnt_q, rst_cnt_d;
   logic            load_ready_q, load_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cpu_rst_q, cpu_rst_d;
   logic [5:0]      cpu_instr_q, cpu_instr_d;
   logic [5:0]      mem_q [DEPTH];
   logic            mem_we_s;
   logic [AW:0]     last_idx_s;
   logic            issue_ok_s;

`ifdef HIDDENCPU_FEEDER_STEP_EN
   logic            step_mode_q, step_mode_d;
   assign issue_ok_s = ~step_mode_q | step;
`else
   assign issue_ok_s = 1'b1;
`endif

   assign last_idx_s = prog_len_q - (AW+1)'(1);

   // Next-state and next-output logic for the feeder controller
   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      prog_len_d   = prog_len_q;
      loops_left_d = loops_left_q;
      rst_cnt_d    = rst_cnt_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      cpu_rst_d    = 1'b0;
      cpu_instr_d  = IDLE_INSTR;
      mem_we_s     = 1'b0;
`ifdef HIDDENCPU_FEEDER_STEP_EN
      step_mode_d  = step_mode_q;
`endif
      case (state_q)
         S_IDLE: begin
            // an accepted start swallows any load or clear presented in the same cycle
            if (start && (prog_len_q != {(AW+1){1'b0}})) begin
               loops_left_d = repeat_cnt;
               rd_ptr_d     = {AW{1'b0}};
               rst_cnt_d    = CW'(RST_CYCLES);
`ifdef HIDDENCPU_FEEDER_STEP_EN
               step_mode_d  = step_mode;
`endif
               state_d      = S_RESET_CPU;
            end else if (clear) begin
               prog_len_d = {(AW+1){1'b0}};
            end else if (load_valid && load_ready_q) begin
               mem_we_s   = 1'b1;
               prog_len_d = prog_len_q + (AW+1)'(1);
            end else begin
               prog_len_d = prog_len_q;
            end
         end
         S_RESET_CPU: begin
            if (abort) begin
               cpu_rst_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               busy_d    = 1'b1;
               cpu_rst_d = 1'b1;
               if (rst_cnt_q == CW'(1)) begin
                  state_d = S_RUN;
               end else begin
                  rst_cnt_d = rst_cnt_q - CW'(1);
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               cpu_rst_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               busy_d = 1'b1;
               if (issue_ok_s) begin
                  cpu_instr_d = mem_q[rd_ptr_q];
                  if ({1'b0, rd_ptr_q} == last_idx_s) begin
                     if (loops_left_q != 8'd0) begin
                        loops_left_d = loops_left_q - 8'd1;
                        rd_ptr_d     = {AW{1'b0}};
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     rd_ptr_d = rd_ptr_q + AW'(1);
                  end
               end else begin
                  cpu_instr_d = IDLE_INSTR;
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // ready only while the coming cycle is an IDLE cycle with buffer space left
      load_ready_d = (state_d == S_IDLE) && (prog_len_d < (AW+1)'(DEPTH));
   end

   // Controller state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rd_ptr_q     <= {AW{1'b0}};
         prog_len_q   <= {(AW+1){1'b0}};
         loops_left_q <= 8'd0;
         rst_cnt_q    <= {CW{1'b0}};
         load_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cpu_rst_q    <= 1'b1;
         cpu_instr_q  <= IDLE_INSTR;
`ifdef HIDDENCPU_FEEDER_STEP_EN
         step_mode_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         prog_len_q   <= prog_len_d;
         loops_left_q <= loops_left_d;
         rst_cnt_q    <= rst_cnt_d;
         load_ready_q <= load_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cpu_rst_q    <= cpu_rst_d;
         cpu_instr_q  <= cpu_instr_d;
`ifdef HIDDENCPU_FEEDER_STEP_EN
         step_mode_q  <= step_mode_d;
`endif
      end
   end

   // Program buffer write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[prog_len_q[AW-1:0]] <= load_data;
      end
   end

   assign load_ready = load_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign prog_len   = prog_len_q;
   assign cpu_rst    = cpu_rst_q;
   assign cpu_instr  = cpu_instr_q;

endmodule

// File: tb/tb_hidden_cpu_prog_feeder.sv
// Directed bench for hidden_cpu_prog_feeder with a program-level output model checked every cycle.
module tb_hidden_cpu_prog_feeder;
   localparam int         DEPTH      = 16;
   localparam int         AW         = 4;
   localparam int         RST_CYCLES = 2;
   localparam logic [5:0] IDLE_I     = 6'b000000;

   logic          clk = 1'b0;
   logic          rst, load_valid, load_ready, clear, start, abort;
   logic          busy, done, cpu_rst;
   logic [5:0]    load_data, cpu_instr;
   logic [7:0]    repeat_cnt;
   logic [AW:0]   prog_len;
`ifdef HIDDENCPU_FEEDER_STEP_EN
   logic          step, step_mode;
`endif

   always #5 clk = ~clk;

   hidden_cpu_prog_feeder #(.DEPTH(DEPTH), .AW(AW), .RST_CYCLES(RST_CYCLES), .IDLE_INSTR(IDLE_I)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .clear(clear), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
`ifdef HIDDENCPU_FEEDER_STEP_EN
      .step(step), .step_mode(step_mode),
`endif
      .busy(busy), .done(done), .prog_len(prog_len),
      .cpu_rst(cpu_rst), .cpu_instr(cpu_instr)
   );

   // expected output vector per cycle: {cpu_rst, cpu_instr, busy, done, load_ready, prog_len}
   logic [14:0] exp_q[$];
   logic [5:0]  m_mem[$];
   logic [5:0]  seen[$];
   bit          m_ready;
   int          done_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [14:0] mk(bit r, logic [5:0] i, bit b, bit d, bit rd, int len);
      return {r, i, b, d, rd, 5'(len)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         check("cycle{rst,instr,busy,done,rdy,len}",
               {17'd0, cpu_rst, cpu_instr, busy, done, load_ready, prog_len},
               {17'd0, exp_q.pop_front()});
      end
      if (busy && !cpu_rst) seen.push_back(cpu_instr);
      if (done) done_cnt++;
   end

   task automatic cyc(input logic [14:0] e);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycle(input bit v, input logic [5:0] d, input bit clr);
      load_valid = v; load_data = d; clear = clr;
      if (clr) m_mem.delete();
      else if (v && m_ready) m_mem.push_back(d);
      m_ready = (m_mem.size() < DEPTH);
      cyc(mk(1'b0, IDLE_I, 1'b0, 1'b0, m_ready, m_mem.size()));
      load_valid = 1'b0; clear = 1'b0;
   endtask

   // start a run; abort_at = index of the RUN cycle carrying abort (0 = none)
   task automatic run_prog(input int rep, input int abort_at, input bit stepped);
      int len, total, k, c;
      bit go;
      len = m_mem.size();
      seen.delete();
      done_cnt = 0;
      start = 1'b1; repeat_cnt = 8'(rep);
      load_valid = 1'b1; load_data = 6'h2A;
`ifdef HIDDENCPU_FEEDER_STEP_EN
      step_mode = stepped;
`endif
      cyc(mk(1'b0, IDLE_I, 1'b0, 1'b0, 1'b0, len));
      start = 1'b0; load_valid = 1'b0;
      for (int r = 0; r < RST_CYCLES; r++) cyc(mk(1'b1, IDLE_I, 1'b1, 1'b0, 1'b0, len));
      total = len * (rep + 1);
      k = 0; c = 0;
      while (k < total) begin
         c++;
         if (c == abort_at) begin
            abort = 1'b1;
            m_ready = (len < DEPTH);
            cyc(mk(1'b1, IDLE_I, 1'b0, 1'b0, m_ready, len));
            abort = 1'b0;
            return;
         end
         go = !stepped || (c % 3 == 0);
`ifdef HIDDENCPU_FEEDER_STEP_EN
         step = stepped && go;
`endif
         if (go) begin
            cyc(mk(1'b0, m_mem[k % len], 1'b1, 1'b0, 1'b0, len));
            k++;
         end else begin
            cyc(mk(1'b0, IDLE_I, 1'b1, 1'b0, 1'b0, len));
         end
`ifdef HIDDENCPU_FEEDER_STEP_EN
         step = 1'b0;
`endif
      end
      m_ready = (len < DEPTH);
      cyc(mk(1'b0, IDLE_I, 1'b0, 1'b1, m_ready, len));
   endtask

   task automatic load3();
      idle_cycle(1'b1, 6'h1B, 1'b0);
      idle_cycle(1'b1, 6'h24, 1'b0);
      idle_cycle(1'b1, 6'h3F, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = 6'd0; clear = 1'b0;
      start = 1'b0; repeat_cnt = 8'd0; abort = 1'b0;
`ifdef HIDDENCPU_FEEDER_STEP_EN
      step = 1'b0; step_mode = 1'b0;
`endif
      m_ready = 1'b0; done_cnt = 0;
      cyc(mk(1'b1, IDLE_I, 1'b0, 1'b0, 1'b0, 0));
      cyc(mk(1'b1, IDLE_I, 1'b0, 1'b0, 1'b0, 0));
      rst = 1'b0;
      idle_cycle(1'b0, 6'd0, 1'b0);

      // 1: load three words without backpressure
      load3();
      check("len_after_load", 32'(prog_len), 32'd3);
      check("ready_after_load", 32'(load_ready), 32'd1);

      // 2: single pass
      run_prog(0, 0, 1'b0);
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("p1_count", seen.size(), 32'd3);
      check("p1_w0", 32'(seen[0]), 32'h1B);
      check("p1_w1", 32'(seen[1]), 32'h24);
      check("p1_w2", 32'(seen[2]), 32'h3F);
      check("p1_done", done_cnt, 32'd1);

      // 3: three passes back to back
      run_prog(2, 0, 1'b0);
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("p3_count", seen.size(), 32'd9);
      check("p3_w5", 32'(seen[5]), 32'h3F);
      check("p3_w6", 32'(seen[6]), 32'h1B);
      check("p3_done", done_cnt, 32'd1);

      // 4: overfill, clear priority, empty start
      idle_cycle(1'b0, 6'd0, 1'b1);
      for (int i = 0; i < 17; i++) idle_cycle(1'b1, 6'(i + 1), 1'b0);
      check("len_full", 32'(prog_len), 32'd16);
      check("ready_full", 32'(load_ready), 32'd0);
      idle_cycle(1'b1, 6'h15, 1'b1);
      check("len_cleared", 32'(prog_len), 32'd0);
      start = 1'b1;
      idle_cycle(1'b0, 6'd0, 1'b0);
      start = 1'b0;
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("empty_start_rst", 32'(cpu_rst), 32'd0);
      check("empty_start_busy", 32'(busy), 32'd0);

      // 5: abort on second RUN cycle, then replay
      load3();
      run_prog(0, 2, 1'b0);
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("abort_count", seen.size(), 32'd1);
      check("abort_no_done", done_cnt, 32'd0);
      run_prog(0, 0, 1'b0);
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("replay_w0", 32'(seen[0]), 32'h1B);
      check("replay_count", seen.size(), 32'd3);

`ifdef HIDDENCPU_FEEDER_STEP_EN
      // 6: stepped issue, one word every third RUN cycle
      run_prog(0, 0, 1'b1);
      idle_cycle(1'b0, 6'd0, 1'b0);
      check("step_cycles", seen.size(), 32'd9);
      check("step_w2", 32'(seen[2]), 32'h1B);
      check("step_done", done_cnt, 32'd1);
`endif

      idle_cycle(1'b0, 6'd0, 1'b0);
      @(negedge clk);
      #1;
      check("exp_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hidden_cpu_prog_feeder.md
Name: hidden_cpu_prog_feeder

Overview:
Host-side program streamer that drives the instruction end of the HiddenCPU pin interface: io_in[1] is reset and io_in[7:2] is the 6-bit instruction {opcode[1:0], ra[1:0], rb[1:0]}. The CPU samples io_in[7:2] on every posedge.
- The feeder accepts a program through a valid/ready load port and stores it in a small buffer.
- It holds the CPU in reset for a fixed window.
- It then streams one instruction per clock, with optional whole-program repeats.
- It shares clk with the CPU. Its outputs map directly onto io_in[7:1].

Parameters:
DEPTH, 16, program buffer entries (power of two, 2..64)
AW, 4, buffer address width, equal to log2(DEPTH)
RST_CYCLES, 2, cycles cpu_rst is held high before the first instruction (at least 1)
IDLE_INSTR, 6'b000000, instruction driven whenever no program instruction is being issued

Ports:
clk  in  1  clock, shared with the CPU
rst  in  1  synchronous, active-high reset
load_valid  in  1  program word valid
load_ready  out  1  feeder can accept a program word
load_data  in  6  instruction word {op, ra, rb}
clear  in  1  discard the stored program (honoured in IDLE only)
start  in  1  begin a run (sampled in IDLE only)
repeat_cnt  in  8  extra passes over the program, latched at start
abort  in  1  terminate a run immediately
busy  out  1  high in RESET_CPU and RUN
done  out  1  one-cycle pulse when a run completes normally
prog_len  out  AW+1  number of stored words (0..DEPTH)
cpu_rst  out  1  drives CPU io_in[1]
cpu_instr  out  6  drives CPU io_in[7:2]

Behaviour:
Reset values (rst high at a posedge; takes priority over every other input):
- State = IDLE; wr_ptr, rd_ptr and prog_len = 0.
- cpu_rst = 1, cpu_instr = IDLE_INSTR.
- busy = 0, done = 0, load_ready = 0.
- The buffer contents are not reset.
- In the first IDLE cycle after reset: cpu_rst = 0 and load_ready = 1.

All outputs are registered.

States are IDLE, RESET_CPU, RUN, DONE.

IDLE:
- load_ready = (prog_len < DEPTH).
- On load_valid & load_ready: mem[prog_len] <= load_data and prog_len increments.
- When the buffer is full, load_ready = 0 and writes are dropped.
- clear sets prog_len = 0 and has priority over a load in the same cycle.
- start with prog_len != 0: latch loops_left = repeat_cnt, set rd_ptr = 0, go to RESET_CPU.
- start with prog_len == 0 is ignored.
- start has priority over a load in the same cycle; that load is not performed.
- cpu_instr = IDLE_INSTR.

RESET_CPU:
- cpu_rst = 1 for exactly RST_CYCLES cycles, counted by a down-counter.
- cpu_instr = IDLE_INSTR.
- load_ready = 0.
- Then go to RUN.

RUN:
- Each cycle: cpu_instr <= mem[rd_ptr] and cpu_rst = 0.
- When the issued word is at rd_ptr == prog_len-1:
  - if loops_left != 0: decrement loops_left and set rd_ptr = 0;
  - otherwise go to DONE.
- Otherwise rd_ptr increments.
- No gap between passes. Total issued words = prog_len × (repeat_cnt+1).
- Latency: start sampled at edge N → cpu_rst high at edges N+1..N+RST_CYCLES → mem[0] on cpu_instr after edge N+RST_CYCLES+1.

DONE:
- One cycle: done = 1, cpu_instr = IDLE_INSTR.
- Then go to IDLE. The program is retained, so start can re-run it.

Abort:
- abort in RESET_CPU or RUN: next cycle cpu_rst = 1 for one cycle, cpu_instr = IDLE_INSTR, state = IDLE.
- done is not pulsed. abort in IDLE or DONE is ignored.
- Reset mid-run (rst high): return to the reset values immediately. The buffer contents are not reset, but the program is lost because prog_len = 0.

Other rules:
- busy = 1 exactly in RESET_CPU and RUN.
- prog_len is stable during a run.

Optional Feature:
HIDDENCPU_FEEDER_STEP_EN
- Defined:
  - Adds input step (1 bit) and input step_mode (1 bit); step_mode is latched at start.
  - With step_mode = 1, RUN issues the next program word only in a cycle where step = 1; other cycles drive IDLE_INSTR and hold rd_ptr.
  - abort still applies.
  - The end-of-program and repeat rules are unchanged and count issued words only.
- Undefined: no step or step_mode ports; RUN issues a word every cycle.

Test Plan:
1. Reset, then load 3 words (0x1B, 0x24, 0x3F) with no backpressure → prog_len = 3, load_ready stays 1.
2. Start with repeat_cnt = 0 → cpu_rst high for 2 cycles, then cpu_instr = 0x1B, 0x24, 0x3F on consecutive cycles. Then done pulses for 1 cycle with cpu_instr = 0x00, and busy drops.
3. Same program, start with repeat_cnt = 2 → 9 back-to-back words, the 3-word sequence three times with no gap, then a single done pulse.
4. Load 17 words with DEPTH = 16 → load_ready drops after the 16th word, the 17th is dropped, prog_len = 16. clear → prog_len = 0. start with prog_len = 0 → no state change, cpu_rst stays 0.
5. abort on the 2nd RUN cycle → next cycle cpu_rst = 1 and cpu_instr = 0x00 for one cycle, then IDLE with no done pulse. A following start replays from mem[0].
6. (STEP_EN defined) step_mode = 1, with step pulsed on every 3rd cycle → each program word appears only in step cycles and 0x00 otherwise. done follows the last stepped word.
